// File: rtl/ysyx_22040632_gpr_scoreboard_pkg.sv
// Shared core package: default register-file geometry and basic types.
// Imported by the GPR scoreboard and its popcount helper.
package ysyx_22040632_RISCV_PKG;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;

  typedef logic [4:0]  regaddr_t;
  typedef logic [63:0] xlen_t;

endpackage

// File: rtl/ysyx_22040632_gpr_scoreboard_popcount.sv
// Combinational population count.
// Ports: in_i [W] bits to count, cnt_o [OW] number of set bits.
module ysyx_22040632_popcount
  import ysyx_22040632_RISCV_PKG::*;
#(
  parameter int W  = NREGS_DEF,
  parameter int OW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_i,
  output logic [OW-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + OW'(in_i[i]);
    end
  end

endmodule

// File: rtl/ysyx_22040632_gpr_scoreboard.sv
// GPR file with per-register busy scoreboard for the pipelined core.
// Ports: clk/rrst_n; NRD comb read ports (rd_en/rd_addr/rd_data/rd_busy);
// issue port (iss_valid/iss_wen/iss_rd/iss_ready); writeback port
// (wb_valid/wb_rd/wb_data); flush; busy_cnt registered busy popcount.
// Optional same-cycle writeback bypass: YSYX_22040632_RF_BYPASS_EN.
module ysyx_22040632_gpr_scoreboard
  import ysyx_22040632_RISCV_PKG::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rrst_n,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              iss_valid,
  input  logic              iss_wen,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_ready,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic [AW:0]       busy_cnt
);

  logic [XLEN-1:0]  gpr_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] busy_eff;
  logic [NREGS-1:0] wb_oh;
  logic [AW:0]      cnt_q, cnt_d;

  assign wb_oh = wb_valid ? (NREGS'(1) << wb_rd) : '0;

`ifdef YSYX_22040632_RF_BYPASS_EN
  // The producer retires this cycle, so its consumers may go now.
  assign busy_eff = busy_q & ~wb_oh;
`else
  assign busy_eff = busy_q;
`endif

  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    a       = '0;
    d       = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      a = rd_addr[i*AW +: AW];
      d = gpr_q[a];
`ifdef YSYX_22040632_RF_BYPASS_EN
      if (wb_valid && (wb_rd == a)) d = wb_data;
`endif
      if (a == '0) d = '0;
      rd_data[i*XLEN +: XLEN] = d;
      rd_busy[i] = rd_en[i] & busy_eff[a] & (a != '0);
    end
  end

  assign iss_ready = iss_valid
                   & ~(|rd_busy)
                   & ~(iss_wen & busy_eff[iss_rd]);

  // Clear, then set (new producer wins), then flush overrides both.
  always_comb begin
    busy_d = busy_q & ~wb_oh;
    if (iss_ready && iss_wen && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  ysyx_22040632_popcount #(
    .W  (NREGS),
    .OW (AW + 1)
  ) u_popcount (
    .in_i  (busy_d),
    .cnt_o (cnt_d)
  );

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        gpr_q[r] <= '0;
      end
    end else if (wb_valid && (wb_rd != '0)) begin
      gpr_q[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_22040632_gpr_scoreboard.sv
// Directed self-checking bench for the GPR scoreboard.
// Expectations follow the bypass macro when it is defined.
module tb_ysyx_22040632_gpr_scoreboard;

`ifdef YSYX_22040632_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk;
  logic         rrst_n;
  logic [1:0]   rd_en;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [1:0]   rd_busy;
  logic         iss_valid;
  logic         iss_wen;
  logic [4:0]   iss_rd;
  logic         iss_ready;
  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic [63:0]  wb_data;
  logic         flush;
  logic [5:0]   busy_cnt;

  int checks;
  int errors;

  ysyx_22040632_gpr_scoreboard dut (
    .clk       (clk),
    .rrst_n    (rrst_n),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_wen   (iss_wen),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .flush     (flush),
    .busy_cnt  (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en     = 2'b00;
    rd_addr   = '0;
    iss_valid = 1'b0;
    iss_wen   = 1'b0;
    iss_rd    = '0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    flush     = 1'b0;
  endtask

  task automatic issue(input logic [4:0] r);
    iss_valid = 1'b1;
    iss_wen   = 1'b1;
    iss_rd    = r;
    step();
    iss_valid = 1'b0;
    iss_wen   = 1'b0;
  endtask

  task automatic test_reset();
    rd_en   = 2'b11;
    rd_addr = {5'd5, 5'd5};
    #1;
    checks++;
    if (rd_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_rd_data got %h exp 0", rd_data);
    end
    checks++;
    if (rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL reset_rd_busy got %b exp 00", rd_busy);
    end
    checks++;
    if (busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL reset_busy_cnt got %0d exp 0", busy_cnt);
    end
    iss_valid = 1'b1;
    iss_wen   = 1'b1;
    iss_rd    = 5'd1;
    #1;
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_iss_ready got %b exp 1", iss_ready);
    end
    idle();
  endtask

  task automatic test_write();
    logic [63:0] exp;
    step();
    wb_valid = 1'b1;
    wb_rd    = 5'd3;
    wb_data  = 64'hDEAD_BEEF;
    rd_en    = 2'b00;
    rd_addr  = {5'd0, 5'd3};
    #1;
    exp = BYP ? 64'hDEAD_BEEF : 64'h0;
    checks++;
    if (rd_data[63:0] !== exp) begin
      errors++;
      $display("FAIL wb_same_cycle got %h exp %h", rd_data[63:0], exp);
    end
    step();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (rd_data[63:0] !== 64'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wb_visible got %h exp deadbeef", rd_data[63:0]);
    end
    wb_valid = 1'b1;
    wb_rd    = 5'd0;
    wb_data  = 64'h1;
    step();
    wb_valid = 1'b0;
    rd_addr  = {5'd0, 5'd3};
    #1;
    checks++;
    if (rd_data[127:64] !== 64'h0) begin
      errors++;
      $display("FAIL x0_read got %h exp 0", rd_data[127:64]);
    end
    checks++;
    if (busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL wb_nonbusy_cnt got %0d exp 0", busy_cnt);
    end
  endtask

  task automatic test_raw();
    logic       e_rdy;
    logic [1:0] e_bsy;
    step();
    iss_valid = 1'b1;
    iss_wen   = 1'b1;
    iss_rd    = 5'd7;
    #1;
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_issue_ready got %b exp 1", iss_ready);
    end
    step();
    iss_wen = 1'b0;
    rd_en   = 2'b01;
    rd_addr = {5'd0, 5'd7};
    #1;
    checks++;
    if (busy_cnt !== 6'd1) begin
      errors++;
      $display("FAIL raw_busy_cnt got %0d exp 1", busy_cnt);
    end
    checks++;
    if (rd_busy !== 2'b01 || iss_ready !== 1'b0) begin
      errors++;
      $display("FAIL raw_stall got busy=%b rdy=%b exp 01/0",
               rd_busy, iss_ready);
    end
    step();
    wb_valid = 1'b1;
    wb_rd    = 5'd7;
    wb_data  = 64'h42;
    #1;
    e_rdy = BYP;
    e_bsy = BYP ? 2'b00 : 2'b01;
    checks++;
    if (iss_ready !== e_rdy || rd_busy !== e_bsy) begin
      errors++;
      $display("FAIL raw_wb_cycle got rdy=%b busy=%b exp %b/%b",
               iss_ready, rd_busy, e_rdy, e_bsy);
    end
    step();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (iss_ready !== 1'b1 || rd_data[63:0] !== 64'h42) begin
      errors++;
      $display("FAIL raw_after_wb got rdy=%b data=%h exp 1/42",
               iss_ready, rd_data[63:0]);
    end
    checks++;
    if (busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL raw_release_cnt got %0d exp 0", busy_cnt);
    end
    idle();
  endtask

  task automatic test_waw();
    logic [5:0] e_cnt;
    step();
    issue(5'd9);
    iss_valid = 1'b1;
    iss_wen   = 1'b1;
    iss_rd    = 5'd9;
    #1;
    checks++;
    if (iss_ready !== 1'b0) begin
      errors++;
      $display("FAIL waw_stall got %b exp 0", iss_ready);
    end
    step();
    wb_valid = 1'b1;
    wb_rd    = 5'd9;
    wb_data  = 64'h5;
    #1;
    checks++;
    if (iss_ready !== BYP) begin
      errors++;
      $display("FAIL waw_wb_cycle got %b exp %b", iss_ready, BYP);
    end
    step();
    wb_valid = 1'b0;
    #1;
    e_cnt = BYP ? 6'd1 : 6'd0;
    checks++;
    if (busy_cnt !== e_cnt || iss_ready !== !BYP) begin
      errors++;
      $display("FAIL waw_after_wb got cnt=%0d rdy=%b exp %0d/%b",
               busy_cnt, iss_ready, e_cnt, !BYP);
    end
    idle();
    wb_valid = 1'b1;
    wb_rd    = 5'd9;
    step();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL waw_drain_cnt got %0d exp 0", busy_cnt);
    end
  endtask

  task automatic test_flush();
    step();
    issue(5'd4);
    issue(5'd5);
    issue(5'd6);
    checks++;
    if (busy_cnt !== 6'd3) begin
      errors++;
      $display("FAIL flush_pre_cnt got %0d exp 3", busy_cnt);
    end
    flush     = 1'b1;
    wb_valid  = 1'b1;
    wb_rd     = 5'd4;
    wb_data   = 64'h11;
    iss_valid = 1'b1;
    iss_wen   = 1'b1;
    iss_rd    = 5'd8;
    #1;
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_iss_ready got %b exp 1", iss_ready);
    end
    step();
    idle();
    rd_en   = 2'b11;
    rd_addr = {5'd8, 5'd4};
    #1;
    checks++;
    if (busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL flush_cnt got %0d exp 0", busy_cnt);
    end
    checks++;
    if (rd_data[63:0] !== 64'h11) begin
      errors++;
      $display("FAIL flush_wb_data got %h exp 11", rd_data[63:0]);
    end
    checks++;
    if (rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL flush_rd_busy got %b exp 00", rd_busy);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    step();
    issue(5'd10);
    issue(5'd11);
    rd_en   = 2'b11;
    rd_addr = {5'd10, 5'd3};
    #1;
    checks++;
    if (busy_cnt !== 6'd2 || rd_data[63:0] !== 64'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rstmid_pre got cnt=%0d d=%h exp 2/deadbeef",
               busy_cnt, rd_data[63:0]);
    end
    rrst_n = 1'b0;
    #1;
    checks++;
    if (rd_data !== 128'h0 || rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_reads got d=%h b=%b exp 0/00",
               rd_data, rd_busy);
    end
    checks++;
    if (busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL rstmid_cnt got %0d exp 0", busy_cnt);
    end
    step();
    rrst_n = 1'b1;
    step();
    checks++;
    if (rd_data[63:0] !== 64'h0 || busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL rstmid_release got d=%h cnt=%0d exp 0/0",
               rd_data[63:0], busy_cnt);
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rrst_n = 1'b0;
    step();
    step();
    rrst_n = 1'b1;
    test_reset();
    test_write();
    test_raw();
    test_waw();
    test_flush();
    test_reset_mid();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
